// File: rtl/pulse_stretch_multi.sv
// Multi-channel programmable pulse stretcher / pulse-to-toggle converter.
// Widens single-cycle fast-domain pulses so a slower domain can sample them.
module pulse_stretch_multi #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_retrig,
    input  logic             cfg_toggle,
    input  logic [NCH-1:0]   pulse_in,
    input  logic             ovf_clr,
    output logic [NCH-1:0]   pulse_out,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   ovf
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state [NCH];
    logic [LEN_W-1:0] cnt   [NCH];
    logic             toggle_q;
    logic [LEN_W-1:0] len_m1;
    logic             mode_chg;
    logic [NCH-1:0]   ovf_set;

    // A programmed length of zero behaves as a length of one.
    assign len_m1   = (cfg_len == '0) ? '0 : cfg_len - LEN_W'(1);
    assign mode_chg = (cfg_toggle != toggle_q);

    // Pulses dropped inside a running window when retrigger is off.
    always_comb begin
        ovf_set = '0;
        if (en && !mode_chg && !cfg_toggle) begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (state[i] == ACTIVE && cnt[i] != '0 && pulse_in[i] && !cfg_retrig)
                    ovf_set[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_q  <= 1'b0;
            pulse_out <= '0;
            busy      <= '0;
            ovf       <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            toggle_q <= cfg_toggle;
            // Set wins over a simultaneous clear.
            ovf      <= (ovf & ~{NCH{ovf_clr}}) | ovf_set;
            for (int i = 0; i < int'(NCH); i++) begin
                if (!en || mode_chg) begin
                    state[i]     <= IDLE;
                    cnt[i]       <= '0;
                    pulse_out[i] <= 1'b0;
                    busy[i]      <= 1'b0;
                end else if (cfg_toggle) begin
                    state[i] <= IDLE;
                    cnt[i]   <= '0;
                    busy[i]  <= 1'b0;
                    if (pulse_in[i])
                        pulse_out[i] <= ~pulse_out[i];
                end else begin
                    unique case (state[i])
                        IDLE: begin
                            if (pulse_in[i]) begin
                                state[i]     <= ACTIVE;
                                cnt[i]       <= len_m1;
                                pulse_out[i] <= 1'b1;
                                busy[i]      <= 1'b1;
                            end else begin
                                pulse_out[i] <= 1'b0;
                                busy[i]      <= 1'b0;
                            end
                        end
                        ACTIVE: begin
                            // Last cycle of a window always accepts a new trigger seamlessly.
                            if (pulse_in[i] && (cnt[i] == '0 || cfg_retrig)) begin
                                cnt[i]       <= len_m1;
                                pulse_out[i] <= 1'b1;
                                busy[i]      <= 1'b1;
                            end else if (cnt[i] != '0) begin
                                cnt[i]       <= cnt[i] - LEN_W'(1);
                                pulse_out[i] <= 1'b1;
                                busy[i]      <= 1'b1;
                            end else begin
                                state[i]     <= IDLE;
                                pulse_out[i] <= 1'b0;
                                busy[i]      <= 1'b0;
                            end
                        end
                        default: begin
                            state[i]     <= IDLE;
                            cnt[i]       <= '0;
                            pulse_out[i] <= 1'b0;
                            busy[i]      <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_stretch_multi.sv
// Scoreboard bench for pulse_stretch_multi: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_pulse_stretch_multi;

    localparam int unsigned NCH   = 4;
    localparam int unsigned LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_retrig;
    logic             cfg_toggle;
    logic [NCH-1:0]   pulse_in;
    logic             ovf_clr;
    logic [NCH-1:0]   pulse_out;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   ovf;

    typedef struct {
        int             cyc;
        logic [NCH-1:0] po;
        logic [NCH-1:0] bsy;
        logic [NCH-1:0] ov;
        string          name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    pulse_stretch_multi #(.NCH(NCH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_len   (cfg_len),
        .cfg_retrig(cfg_retrig),
        .cfg_toggle(cfg_toggle),
        .pulse_in  (pulse_in),
        .ovf_clr   (ovf_clr),
        .pulse_out (pulse_out),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input string field,
                       input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s @cyc %0d: got %b expected %b", name, field, cyc, act, exp);
        end
    endtask

    // Monitor: outputs are registered, so every cycle presents a new sample.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk(e.name, "pulse_out", pulse_out, e.po);
            chk(e.name, "busy", busy, e.bsy);
            chk(e.name, "ovf", ovf, e.ov);
        end
    end

    // Bit c of pin/clr/enoff drives cycle c; bit c of epo/eovf is the expected output in cycle c.
    task automatic run_seq(input string name, input int n, input logic [NCH-1:0] mask,
                           input logic tog, input logic [31:0] pin, input logic [31:0] clr,
                           input logic [31:0] enoff, input logic [31:0] epo,
                           input logic [31:0] eovf);
        exp_t it;
        for (int c = 0; c < n; c++) begin
            pulse_in = pin[c] ? mask : '0;
            ovf_clr  = clr[c];
            en       = !enoff[c];
            it.cyc   = cyc + 1;
            it.po    = epo[c+1] ? mask : '0;
            it.bsy   = (!tog && epo[c+1]) ? mask : '0;
            it.ov    = eovf[c+1] ? mask : '0;
            it.name  = name;
            sb.push_back(it);
            @(posedge clk);
            #1;
        end
        pulse_in = '0;
        ovf_clr  = 1'b0;
        en       = 1'b1;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        cfg_len    = 4'd2;
        cfg_retrig = 1'b0;
        cfg_toggle = 1'b0;
        pulse_in   = '0;
        ovf_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", "pulse_out", pulse_out, '0);
        chk("reset", "busy", busy, '0);
        chk("reset", "ovf", ovf, '0);
        rst = 1'b0;
        idle(2);

        cfg_len = 4'd2; cfg_retrig = 1'b0;
        run_seq("t1_len2", 10, 4'h1, 1'b0, 32'h20, 32'h0, 32'h0, 32'hC0, 32'h0);

        cfg_len = 4'd5; cfg_retrig = 1'b1;
        run_seq("t2_retrig", 12, 4'h1, 1'b0, 32'h9, 32'h0, 32'h0, 32'h1FE, 32'h0);

        cfg_retrig = 1'b0;
        run_seq("t3_ovf", 12, 4'h1, 1'b0, 32'h5, 32'h400, 32'h0, 32'h3E, 32'h7F8);

        run_seq("ovf_set_wins", 8, 4'h1, 1'b0, 32'h5, 32'h24, 32'h0, 32'h3E, 32'h38);

        cfg_len = 4'd3; cfg_retrig = 1'b0;
        run_seq("t4_cnt0_r0", 10, 4'h1, 1'b0, 32'h9, 32'h0, 32'h0, 32'h7E, 32'h0);
        cfg_retrig = 1'b1;
        run_seq("t4_cnt0_r1", 10, 4'h1, 1'b0, 32'h9, 32'h0, 32'h0, 32'h7E, 32'h0);

        cfg_len = 4'd0;
        run_seq("len0", 4, 4'h1, 1'b0, 32'h1, 32'h0, 32'h0, 32'h2, 32'h0);

        cfg_len = 4'd2;
        run_seq("all_ch", 5, 4'hF, 1'b0, 32'h1, 32'h0, 32'h0, 32'h6, 32'h0);

        cfg_len = 4'd5; cfg_retrig = 1'b0;
        run_seq("en_off", 8, 4'h2, 1'b0, 32'h5, 32'h0, 32'h4, 32'h6, 32'h0);

        cfg_toggle = 1'b1;
        run_seq("tog_enter", 2, 4'h4, 1'b1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0);
        run_seq("t5_toggle", 10, 4'h4, 1'b1, 32'h31, 32'h0, 32'h0, 32'h7DE, 32'h0);
        cfg_toggle = 1'b0;
        run_seq("tog_exit", 3, 4'h4, 1'b0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0);

        cfg_len = 4'd15;
        run_seq("t6_pre", 4, 4'h2, 1'b0, 32'h1, 32'h0, 32'h0, 32'h1E, 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_async_rst", "pulse_out", pulse_out, '0);
        chk("t6_async_rst", "busy", busy, '0);
        chk("t6_async_rst", "ovf", ovf, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        run_seq("t6_post", 18, 4'h2, 1'b0, 32'h1, 32'h0, 32'h0, 32'hFFFE, 32'h0);

        for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
